// File: rtl/btn_gesture_pkg.sv
// Shared definitions for the button gesture decoder.
// - gesture_state_t: the decoder FSM states (the game-control FSM uses them too)
// - DEF_*: default tick constants (ticks of the external timebase strobe)
package btn_gesture_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESSED  = 3'd1,
    HELD     = 3'd2,
    WAIT_DBL = 3'd3,
    SECOND   = 3'd4
  } gesture_state_t;

  localparam int DEF_CNT_WIDTH    = 16;
  localparam int DEF_LONG_TICKS   = 500;
  localparam int DEF_DOUBLE_TICKS = 250;
  localparam int DEF_REPEAT_DELAY = 300;
  localparam int DEF_REPEAT_RATE  = 100;

endpackage

// File: rtl/gesture_timer.sv
// Tick-enabled gesture timer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to 0 (wins over tick)
//   tick       : count enable, one increment per strobe
//   terminal   : value compared against the current count
//   tc         : high when tick arrives while count == terminal
// The counter saturates at all-ones so an idle timer never wraps back
// into a threshold.
module gesture_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 tick,
  input  logic [CNT_WIDTH-1:0] terminal,
  output logic                 tc
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt;

  // Counter: clear has priority, then saturating increment on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign tc = tick && (cnt == terminal);

endmodule

// File: rtl/button_gesture_decoder.sv
// Button gesture decoder: classifies debounced button activity into
// short press, long press (+ auto-repeat) and double click.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   tick            : 1-clk timebase strobe; all timing counts these
//   en              : decoder enable; low forces IDLE with no events
//   button_db       : debounced level
//   button_press    : 1-clk pulse on debounced rising edge
//   button_release  : 1-clk pulse on debounced falling edge
//   short_press     : 1-clk pulse, single press released early, no second press
//   long_press      : 1-clk pulse, LONG_TICKS reached while held
//   repeat_pulse    : 1-clk pulse, auto-repeat while held after long_press
//   double_click    : 1-clk pulse, second press within DOUBLE_TICKS
//   held            : level, decoder is in HELD
module button_gesture_decoder
  import btn_gesture_pkg::*;
#(
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int DOUBLE_TICKS = DEF_DOUBLE_TICKS,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic en,
  input  logic button_db,
  input  logic button_press,
  input  logic button_release,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic double_click,
  output logic held
);

  localparam logic [CNT_WIDTH-1:0] LONG_TC   = CNT_WIDTH'(LONG_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] DOUBLE_TC = CNT_WIDTH'(DOUBLE_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] DELAY_TC  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] RATE_TC   = CNT_WIDTH'(REPEAT_RATE - 1);

  gesture_state_t       state;
  gesture_state_t       state_next;
  logic                 rep_phase;
  logic                 conflict;
  logic                 timer_clear;
  logic                 timer_tick;
  logic                 tc;
  logic [CNT_WIDTH-1:0] terminal;
  logic                 short_ev;
  logic                 long_ev;
  logic                 rep_ev;
  logic                 dbl_ev;

  // Simultaneous press and release is a protocol violation: both are
  // ignored and the timer is frozen so no threshold fires that cycle.
  assign conflict   = button_press && button_release;
  assign timer_tick = tick && !conflict;
  // Every state entry restarts timing; each repeat reloads the interval.
  assign timer_clear = !en || (state_next != state) || rep_ev;

  // Threshold for the current state; HELD switches from the initial
  // repeat delay to the repeat rate once the first repeat has fired.
  always_comb begin
    terminal = '1;
    case (state)
      PRESSED:  terminal = LONG_TC;
      HELD:     terminal = rep_phase ? RATE_TC : DELAY_TC;
      WAIT_DBL: terminal = DOUBLE_TC;
      default:  terminal = '1;
    endcase
  end

  gesture_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .tick     (timer_tick),
    .terminal (terminal),
    .tc       (tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state. Release is checked before the threshold (short path wins)
  // and press before the timeout (double click wins). A low level without
  // a release pulse means the release was missed: drop the gesture.
  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else if (!conflict) begin
      case (state)
        IDLE: begin
          if (button_press) state_next = PRESSED;
        end
        PRESSED: begin
          if (button_release)  state_next = WAIT_DBL;
          else if (!button_db) state_next = IDLE;
          else if (tc)         state_next = HELD;
        end
        HELD: begin
          if (button_release || !button_db) state_next = IDLE;
        end
        WAIT_DBL: begin
          if (button_press) state_next = SECOND;
          else if (tc)      state_next = IDLE;
        end
        SECOND: begin
          if (button_release || !button_db) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Gesture events, derived from the transition being taken.
  always_comb begin
    short_ev = 1'b0;
    long_ev  = 1'b0;
    rep_ev   = 1'b0;
    dbl_ev   = 1'b0;
    if (en && !conflict) begin
      case (state)
        PRESSED:  long_ev = (state_next == HELD);
        HELD:     rep_ev  = (state_next == HELD) && tc;
        WAIT_DBL: begin
          dbl_ev   = (state_next == SECOND);
          short_ev = (state_next == IDLE);
        end
        default: ;
      endcase
    end
  end

  // Tracks whether HELD already produced its first repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_phase <= 1'b0;
    end else if (rep_ev) begin
      rep_phase <= 1'b1;
    end else if (state_next != HELD) begin
      rep_phase <= 1'b0;
    end
  end

  // Registered pulse outputs, one clock after the triggering cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      double_click <= 1'b0;
    end else begin
      short_press  <= short_ev;
      long_press   <= long_ev;
      repeat_pulse <= rep_ev;
      double_click <= dbl_ev;
    end
  end

  assign held = (state == HELD);

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Testbench for button_gesture_decoder with short thresholds
// (LONG=8, DOUBLE=4, RDELAY=4, RRATE=2, one tick every 10 clocks).
// Expected pulse times are computed from the recorded tick times and the
// gesture timing rules; a monitor logs every observed pulse.
module tb_button_gesture_decoder;

  localparam int LONG   = 8;
  localparam int DBL    = 4;
  localparam int RDLY   = 4;
  localparam int RRATE  = 2;
  localparam int TPER   = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic tick;
  logic en;
  logic button_db;
  logic button_press;
  logic button_release;
  logic short_press;
  logic long_press;
  logic repeat_pulse;
  logic double_click;
  logic held;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int phase    = 0;
  int multi_hot = 0;
  int tick_q[$];
  int short_q[$];
  int long_q[$];
  int rep_q[$];
  int dbl_q[$];

  button_gesture_decoder #(
    .CNT_WIDTH    (16),
    .LONG_TICKS   (LONG),
    .DOUBLE_TICKS (DBL),
    .REPEAT_DELAY (RDLY),
    .REPEAT_RATE  (RRATE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick           (tick),
    .en             (en),
    .button_db      (button_db),
    .button_press   (button_press),
    .button_release (button_release),
    .short_press    (short_press),
    .long_press     (long_press),
    .repeat_pulse   (repeat_pulse),
    .double_click   (double_click),
    .held           (held)
  );

  always #5 clk = ~clk;

  // Posedge counter used as the time base for expectations.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: logs the cycle of every output pulse.
  always @(negedge clk) begin
    if (short_press)  short_q.push_back(cyc);
    if (long_press)   long_q.push_back(cyc);
    if (repeat_pulse) rep_q.push_back(cyc);
    if (double_click) dbl_q.push_back(cyc);
    if ($countones({short_press, long_press, repeat_pulse, double_click}) > 1) multi_hot++;
  end

  // One clock of stimulus: tick from the free-running phase, optional
  // press/release pulse with the debounced level following them.
  task automatic drive_cycle(input logic p, input logic r);
    @(negedge clk);
    tick = (phase == 0);
    if (phase == 0) tick_q.push_back(cyc);
    phase = (phase == TPER - 1) ? 0 : phase + 1;
    button_press   = p;
    button_release = r;
    if (p) button_db = 1'b1;
    if (r) button_db = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0);
  endtask

  task automatic run_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      drive_cycle(1'b0, 1'b0);
      if (tick) k++;
    end
  endtask

  task automatic run_until_tick_next();
    while (phase != 0) drive_cycle(1'b0, 1'b0);
  endtask

  // Random idle gap that never reaches the next tick.
  task automatic gap();
    run_cycles($urandom_range(1, 7));
  endtask

  task automatic align_off_tick();
    run_until_tick_next();
    drive_cycle(1'b0, 1'b0);
    gap();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; tick = 1'b0; button_db = 1'b0;
    button_press = 1'b0; button_release = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (short_press !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_short: got %b expected 0", short_press); end
    n_checks++; if (long_press !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_long: got %b expected 0", long_press); end
    n_checks++; if (repeat_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_repeat: got %b expected 0", repeat_pulse); end
    n_checks++; if (double_click !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_double: got %b expected 0", double_click); end
    n_checks++; if (held !== 1'b0)         begin n_fail++; $display("[TB] FAIL reset_held: got %b expected 0", held); end
    rst_n = 1'b1;
    run_ticks(2);
  endtask

  task automatic test_short_press();
    for (int it = 0; it < 4; it++) begin
      int s0, l0, r0, d0, h, rel_base, exp_cyc;
      s0 = short_q.size(); l0 = long_q.size(); r0 = rep_q.size(); d0 = dbl_q.size();
      h = (it == 0) ? 3 : $urandom_range(1, LONG - 1);
      align_off_tick();
      drive_cycle(1'b1, 1'b0);
      run_ticks(h);
      gap();
      rel_base = tick_q.size();
      drive_cycle(1'b0, 1'b1);
      run_ticks(DBL + 2);
      exp_cyc = tick_q[rel_base + DBL - 1] + 1;
      n_checks++;
      if (short_q.size() - s0 !== 1) begin
        n_fail++; $display("[TB] FAIL short_count(h=%0d): got %0d expected 1", h, short_q.size() - s0);
      end else begin
        n_checks++;
        if (short_q[s0] !== exp_cyc) begin
          n_fail++; $display("[TB] FAIL short_time(h=%0d): got cycle %0d expected %0d", h, short_q[s0], exp_cyc);
        end
      end
      n_checks++;
      if ((long_q.size() - l0) + (rep_q.size() - r0) + (dbl_q.size() - d0) !== 0) begin
        n_fail++; $display("[TB] FAIL short_others(h=%0d): got %0d extra pulses expected 0", h,
                           (long_q.size() - l0) + (rep_q.size() - r0) + (dbl_q.size() - d0));
      end
    end
  endtask

  task automatic test_long_press();
    for (int it = 0; it < 2; it++) begin
      int s0, l0, r0, d0, hold, base, exp_long, n_rep;
      int exp_rep[$];
      s0 = short_q.size(); l0 = long_q.size(); r0 = rep_q.size(); d0 = dbl_q.size();
      hold = (it == 0) ? 20 : $urandom_range(LONG + RDLY, 22);
      align_off_tick();
      base = tick_q.size();
      drive_cycle(1'b1, 1'b0);
      run_ticks(hold);
      gap();
      exp_long = tick_q[base + LONG - 1] + 1;
      for (int k = LONG + RDLY; k <= hold; k += RRATE) exp_rep.push_back(tick_q[base + k - 1] + 1);
      n_checks++;
      if (held !== 1'b1) begin n_fail++; $display("[TB] FAIL long_held: got %b expected 1", held); end
      drive_cycle(1'b0, 1'b1);
      drive_cycle(1'b0, 1'b0);
      n_checks++;
      if (held !== 1'b0) begin n_fail++; $display("[TB] FAIL long_held_release: got %b expected 0", held); end
      run_ticks(DBL + 2);
      n_checks++;
      if (long_q.size() - l0 !== 1) begin
        n_fail++; $display("[TB] FAIL long_count(hold=%0d): got %0d expected 1", hold, long_q.size() - l0);
      end else begin
        n_checks++;
        if (long_q[l0] !== exp_long) begin
          n_fail++; $display("[TB] FAIL long_time: got cycle %0d expected %0d", long_q[l0], exp_long);
        end
      end
      n_rep = rep_q.size() - r0;
      n_checks++;
      if (n_rep !== exp_rep.size()) begin
        n_fail++; $display("[TB] FAIL repeat_count(hold=%0d): got %0d expected %0d", hold, n_rep, exp_rep.size());
      end else begin
        for (int j = 0; j < n_rep; j++) begin
          n_checks++;
          if (rep_q[r0 + j] !== exp_rep[j]) begin
            n_fail++; $display("[TB] FAIL repeat_time[%0d]: got cycle %0d expected %0d", j, rep_q[r0 + j], exp_rep[j]);
          end
        end
      end
      n_checks++;
      if ((short_q.size() - s0) + (dbl_q.size() - d0) !== 0) begin
        n_fail++; $display("[TB] FAIL long_no_short: got %0d short/double expected 0",
                           (short_q.size() - s0) + (dbl_q.size() - d0));
      end
    end
  endtask

  task automatic test_double_click();
    for (int it = 0; it < 3; it++) begin
      int s0, l0, r0, d0, a, b, c, pcyc;
      s0 = short_q.size(); l0 = long_q.size(); r0 = rep_q.size(); d0 = dbl_q.size();
      a = (it == 0) ? 2 : $urandom_range(1, LONG - 1);
      b = (it == 0) ? 2 : $urandom_range(1, DBL - 1);
      c = $urandom_range(LONG, LONG + RDLY + 4);
      align_off_tick();
      drive_cycle(1'b1, 1'b0);
      run_ticks(a);
      gap();
      drive_cycle(1'b0, 1'b1);
      run_ticks(b);
      gap();
      drive_cycle(1'b1, 1'b0);
      pcyc = cyc;
      run_ticks(c);
      gap();
      drive_cycle(1'b0, 1'b1);
      run_ticks(DBL + 2);
      n_checks++;
      if (dbl_q.size() - d0 !== 1) begin
        n_fail++; $display("[TB] FAIL double_count(a=%0d b=%0d): got %0d expected 1", a, b, dbl_q.size() - d0);
      end else begin
        n_checks++;
        if (dbl_q[d0] !== pcyc + 1) begin
          n_fail++; $display("[TB] FAIL double_time: got cycle %0d expected %0d", dbl_q[d0], pcyc + 1);
        end
      end
      n_checks++;
      if ((short_q.size() - s0) + (long_q.size() - l0) + (rep_q.size() - r0) !== 0) begin
        n_fail++; $display("[TB] FAIL double_others(c=%0d): got %0d extra pulses expected 0", c,
                           (short_q.size() - s0) + (long_q.size() - l0) + (rep_q.size() - r0));
      end
    end
  endtask

  task automatic test_release_on_threshold();
    int s0, l0, rel_base, exp_cyc;
    s0 = short_q.size(); l0 = long_q.size();
    align_off_tick();
    drive_cycle(1'b1, 1'b0);
    run_ticks(LONG - 1);
    run_until_tick_next();
    rel_base = tick_q.size();
    drive_cycle(1'b0, 1'b1);
    run_ticks(DBL + 2);
    exp_cyc = tick_q[rel_base + DBL] + 1;
    n_checks++;
    if (long_q.size() - l0 !== 0) begin
      n_fail++; $display("[TB] FAIL thr_no_long: got %0d expected 0", long_q.size() - l0);
    end
    n_checks++;
    if (short_q.size() - s0 !== 1) begin
      n_fail++; $display("[TB] FAIL thr_short_count: got %0d expected 1", short_q.size() - s0);
    end else begin
      n_checks++;
      if (short_q[s0] !== exp_cyc) begin
        n_fail++; $display("[TB] FAIL thr_short_time: got cycle %0d expected %0d", short_q[s0], exp_cyc);
      end
    end
  endtask

  task automatic test_press_on_timeout();
    int s0, d0, pcyc;
    s0 = short_q.size(); d0 = dbl_q.size();
    align_off_tick();
    drive_cycle(1'b1, 1'b0);
    run_ticks(2);
    gap();
    drive_cycle(1'b0, 1'b1);
    run_ticks(DBL - 1);
    run_until_tick_next();
    drive_cycle(1'b1, 1'b0);
    pcyc = cyc;
    run_ticks(1);
    gap();
    drive_cycle(1'b0, 1'b1);
    run_ticks(DBL + 2);
    n_checks++;
    if (short_q.size() - s0 !== 0) begin
      n_fail++; $display("[TB] FAIL timeout_no_short: got %0d expected 0", short_q.size() - s0);
    end
    n_checks++;
    if (dbl_q.size() - d0 !== 1) begin
      n_fail++; $display("[TB] FAIL timeout_double_count: got %0d expected 1", dbl_q.size() - d0);
    end else begin
      n_checks++;
      if (dbl_q[d0] !== pcyc + 1) begin
        n_fail++; $display("[TB] FAIL timeout_double_time: got cycle %0d expected %0d", dbl_q[d0], pcyc + 1);
      end
    end
  endtask

  task automatic test_reset_mid_held();
    int s0, l0, r0, d0;
    align_off_tick();
    drive_cycle(1'b1, 1'b0);
    run_ticks(LONG + 1);
    gap();
    n_checks++;
    if (held !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_pre_held: got %b expected 1", held); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({short_press, long_press, repeat_pulse, double_click, held} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL rst_async_outputs: got %b expected 00000",
                         {short_press, long_press, repeat_pulse, double_click, held});
    end
    @(negedge clk);
    rst_n = 1'b1;
    s0 = short_q.size(); l0 = long_q.size(); r0 = rep_q.size(); d0 = dbl_q.size();
    drive_cycle(1'b0, 1'b1);
    run_ticks(LONG + DBL);
    n_checks++;
    if ((short_q.size() - s0) + (long_q.size() - l0) + (rep_q.size() - r0) + (dbl_q.size() - d0) !== 0) begin
      n_fail++; $display("[TB] FAIL rst_late_release: got %0d pulses expected 0",
                         (short_q.size() - s0) + (long_q.size() - l0) + (rep_q.size() - r0) + (dbl_q.size() - d0));
    end
    n_checks++;
    if (held !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_post_held: got %b expected 0", held); end
  endtask

  task automatic test_enable();
    int s0, l0, r0, d0, rel_base, exp_cyc;
    // Disable while waiting for a second press.
    s0 = short_q.size(); l0 = long_q.size(); r0 = rep_q.size(); d0 = dbl_q.size();
    align_off_tick();
    drive_cycle(1'b1, 1'b0);
    run_ticks(1);
    gap();
    drive_cycle(1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0);
    en = 1'b0;
    run_ticks(5);
    en = 1'b1;
    run_ticks(DBL + 2);
    n_checks++;
    if ((short_q.size() - s0) + (long_q.size() - l0) + (rep_q.size() - r0) + (dbl_q.size() - d0) !== 0) begin
      n_fail++; $display("[TB] FAIL en_wait_dbl: got %0d pulses expected 0",
                         (short_q.size() - s0) + (long_q.size() - l0) + (rep_q.size() - r0) + (dbl_q.size() - d0));
    end
    // Normal short press after re-enable.
    s0 = short_q.size();
    align_off_tick();
    drive_cycle(1'b1, 1'b0);
    run_ticks(2);
    gap();
    rel_base = tick_q.size();
    drive_cycle(1'b0, 1'b1);
    run_ticks(DBL + 2);
    exp_cyc = tick_q[rel_base + DBL - 1] + 1;
    n_checks++;
    if (short_q.size() - s0 !== 1) begin
      n_fail++; $display("[TB] FAIL en_short_count: got %0d expected 1", short_q.size() - s0);
    end else begin
      n_checks++;
      if (short_q[s0] !== exp_cyc) begin
        n_fail++; $display("[TB] FAIL en_short_time: got cycle %0d expected %0d", short_q[s0], exp_cyc);
      end
    end
    // Re-enable while the button is still down: no gesture until next press.
    s0 = short_q.size(); l0 = long_q.size(); r0 = rep_q.size(); d0 = dbl_q.size();
    align_off_tick();
    drive_cycle(1'b1, 1'b0);
    run_ticks(1);
    gap();
    en = 1'b0;
    run_ticks(2);
    en = 1'b1;
    run_ticks(LONG + 2);
    n_checks++;
    if (held !== 1'b0) begin n_fail++; $display("[TB] FAIL en_rise_held: got %b expected 0", held); end
    gap();
    drive_cycle(1'b0, 1'b1);
    run_ticks(DBL + 2);
    n_checks++;
    if ((short_q.size() - s0) + (long_q.size() - l0) + (rep_q.size() - r0) + (dbl_q.size() - d0) !== 0) begin
      n_fail++; $display("[TB] FAIL en_rise_pulses: got %0d pulses expected 0",
                         (short_q.size() - s0) + (long_q.size() - l0) + (rep_q.size() - r0) + (dbl_q.size() - d0));
    end
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (multi_hot !== 0) begin
      n_fail++; $display("[TB] FAIL exclusive_pulses: got %0d multi-hot cycles expected 0", multi_hot);
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_press();
    test_double_click();
    test_release_on_threshold();
    test_press_on_timeout();
    test_reset_mid_held();
    test_enable();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
